// File: rtl/lsu_rv64.sv
// lsu_rv64: RV64 load/store unit driving a 64-bit data RAM with grant handshake; define LSU_MISALIGNED_EN to split doubleword-crossing accesses instead of faulting them
module lsu_rv64 #(
  parameter int AddrWidth = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [63:0]          req_wdata,
  output logic                 resp_valid,
  output logic [63:0]          resp_rdata,
  output logic                 resp_fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-4:0] mem_addr,
  output logic [7:0]           mem_be,
  output logic [63:0]          mem_wdata,
  input  logic                 mem_gnt,
  input  logic [63:0]          mem_rdata
);
  localparam int IW = AddrWidth - 3;
  localparam logic [IW-1:0] IDX_ONE = 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BEAT0 = 3'd1;
  localparam logic [2:0] DATA0 = 3'd2;
  localparam logic [2:0] BEAT1 = 3'd3;
  localparam logic [2:0] DATA1 = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;
  logic [2:0]    state, state_nx;
  logic          we_q, flt_q;
  logic [2:0]    f3_q, off_q;
  logic [IW-1:0] idx_q;
  logic [63:0]   wd_q;
  logic [127:0]  rbuf;
  logic          accept, bad_op, mis, req_fault, split;
  logic [7:0]    bytes_q;
  logic [15:0]   lanes;
  logic [127:0]  wsh;
  logic [63:0]   asm_data, ext_data;
  logic          in_b0, in_b1;
  assign accept = req_valid & (state == IDLE);
  assign bad_op = req_we ? req_funct3[2] : (req_funct3 == 3'd7);
`ifdef LSU_MISALIGNED_EN
  assign mis = 1'b0;
`else
  logic [2:0] size_m1;
  assign size_m1 = (req_funct3[1:0] == 2'd0) ? 3'd0 :
                   (req_funct3[1:0] == 2'd1) ? 3'd1 :
                   (req_funct3[1:0] == 2'd2) ? 3'd3 : 3'd7;
  assign mis = |(req_addr[2:0] & size_m1);
`endif
  assign req_fault = bad_op | mis;
  assign bytes_q = (f3_q[1:0] == 2'd0) ? 8'h01 :
                   (f3_q[1:0] == 2'd1) ? 8'h03 :
                   (f3_q[1:0] == 2'd2) ? 8'h0F : 8'hFF;
  assign lanes = {8'h00, bytes_q} << off_q;
  assign split = |lanes[15:8];
  assign wsh = {64'h0, wd_q} << {off_q, 3'b000};
  assign asm_data = 64'(rbuf >> {off_q, 3'b000});
  assign ext_data = (f3_q == 3'd0) ? {{56{asm_data[7]}}, asm_data[7:0]} :
                    (f3_q == 3'd1) ? {{48{asm_data[15]}}, asm_data[15:0]} :
                    (f3_q == 3'd2) ? {{32{asm_data[31]}}, asm_data[31:0]} :
                    (f3_q == 3'd4) ? {56'h0, asm_data[7:0]} :
                    (f3_q == 3'd5) ? {48'h0, asm_data[15:0]} :
                    (f3_q == 3'd6) ? {32'h0, asm_data[31:0]} : asm_data;
  // sequencing: accept, beat(s) held until granted, read data capture, one-cycle response
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? (req_fault ? RESP : BEAT0) : IDLE;
      BEAT0:   state_nx = mem_gnt ? (we_q ? (split ? BEAT1 : RESP) : DATA0) : BEAT0;
      DATA0:   state_nx = split ? BEAT1 : RESP;
      BEAT1:   state_nx = mem_gnt ? (we_q ? RESP : DATA1) : BEAT1;
      DATA1:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register with synchronous active-low abort
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // request fields frozen at acceptance; read beats collected low then high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      flt_q <= 1'b0;
      f3_q  <= 3'd0;
      off_q <= 3'd0;
      idx_q <= '0;
      wd_q  <= 64'h0;
      rbuf  <= 128'h0;
    end else begin
      if (accept) begin
        we_q  <= req_we;
        flt_q <= req_fault;
        f3_q  <= req_funct3;
        off_q <= req_addr[2:0];
        idx_q <= req_addr[AddrWidth-1:3];
        wd_q  <= req_wdata;
      end
      if (state == DATA0) rbuf[63:0] <= mem_rdata;
      if (state == DATA1) rbuf[127:64] <= mem_rdata;
    end
  end
  assign in_b0      = state == BEAT0;
  assign in_b1      = state == BEAT1;
  assign req_ready  = state == IDLE;
  assign mem_req    = in_b0 | in_b1;
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = in_b1 ? idx_q + IDX_ONE : in_b0 ? idx_q : '0;
  assign mem_be     = in_b1 ? lanes[15:8] : in_b0 ? lanes[7:0] : 8'h00;
  assign mem_wdata  = !mem_we ? 64'h0 : in_b1 ? wsh[127:64] : wsh[63:0];
  assign resp_valid = state == RESP;
  assign resp_fault = resp_valid & flt_q;
  assign resp_rdata = (resp_valid & ~we_q & ~flt_q) ? ext_data : 64'h0;
endmodule

// File: tb/tb_lsu_rv64.sv
// tb_lsu_rv64: directed self-checking bench for lsu_rv64 with a grant-controlled RAM model
module tb_lsu_rv64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [13:0] req_addr = 14'h0;
  logic [63:0] req_wdata = 64'h0;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt;
  logic [10:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata, mem_rdata = 64'h0;
  logic        gnt_en = 1'b1;
  logic [63:0] mem [0:2047];
  logic [10:0] lg_addr [0:63];
  logic [7:0]  lg_be [0:63];
  logic [63:0] lg_wd [0:63];
  int          nbeats = 0;
  int          n_chk = 0, n_err = 0;
  int          r_lat, r_nb, nb0;
  logic [63:0] r_data;
  logic        r_fault;
  logic [10:0] h_addr [0:7];
  logic [7:0]  h_be [0:7];
  logic [63:0] h_wd [0:7];
  logic        h_req [0:7];
  assign mem_gnt = gnt_en;
  lsu_rv64 #(.AddrWidth(14)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        for (int i = 0; i < 8; i++)
          if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else mem_rdata <= mem[mem_addr];
      lg_addr[nbeats[5:0]] <= mem_addr;
      lg_be[nbeats[5:0]]   <= mem_be;
      lg_wd[nbeats[5:0]]   <= mem_wdata;
      nbeats <= nbeats + 1;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic we, input logic [2:0] f3, input logic [13:0] a,
                     input logic [63:0] wd, input int hold);
    int cnt;
    @(negedge clk);
    gnt_en = (hold == 0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    nb0 = nbeats;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd;
    cnt = 0; r_lat = -1; r_data = 64'h0; r_fault = 1'b0;
    while (cnt < 40 && r_lat < 0) begin
      @(negedge clk);
      cnt++;
      if (cnt <= hold && cnt < 8) begin
        h_addr[cnt] = mem_addr; h_be[cnt] = mem_be; h_wd[cnt] = mem_wdata; h_req[cnt] = mem_req;
      end
      gnt_en = (cnt > hold);
      if (resp_valid) begin
        r_lat = cnt; r_data = resp_rdata; r_fault = resp_fault;
      end
    end
    if (r_lat < 0) chk("timeout", 64'(r_lat), 64'd0);
    r_nb = nbeats - nb0;
    gnt_en = 1'b1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_fault", 64'(resp_fault), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 3'd3, 14'h010, 64'h1122334455667788, 0);
    chk("sd_lat", 64'(r_lat), 64'd2);
    chk("sd_beats", 64'(r_nb), 64'd1);
    chk("sd_addr", 64'(lg_addr[nb0[5:0]]), 64'd2);
    chk("sd_be", 64'(lg_be[nb0[5:0]]), 64'hFF);
    chk("sd_wdata", lg_wd[nb0[5:0]], 64'h1122334455667788);
    chk("sd_rdata", r_data, 64'h0);
    run(1'b0, 3'd3, 14'h010, 64'h0, 0);
    chk("ld_lat", 64'(r_lat), 64'd3);
    chk("ld_rdata", r_data, 64'h1122334455667788);
    run(1'b1, 3'd0, 14'h013, 64'h80, 0);
    chk("sb_be", 64'(lg_be[nb0[5:0]]), 64'h08);
    chk("sb_wdata", lg_wd[nb0[5:0]], 64'h0000000080000000);
    run(1'b0, 3'd0, 14'h013, 64'h0, 0);
    chk("lb_be", 64'(lg_be[nb0[5:0]]), 64'h08);
    chk("lb_rdata", r_data, 64'hFFFFFFFFFFFFFF80);
    run(1'b0, 3'd4, 14'h013, 64'h0, 0);
    chk("lbu_rdata", r_data, 64'h0000000000000080);
    run(1'b0, 3'd5, 14'h012, 64'h0, 0);
    chk("lhu_rdata", r_data, 64'h0000000000008066);
    run(1'b1, 3'd2, 14'h004, 64'hDEADBEEF, 3);
    chk("sw_hold_lat", 64'(r_lat), 64'd5);
    for (int k = 1; k <= 3; k++) begin
      chk("sw_hold_req", 64'(h_req[k]), 64'd1);
      chk("sw_hold_addr", 64'(h_addr[k]), 64'd0);
      chk("sw_hold_be", 64'(h_be[k]), 64'hF0);
      chk("sw_hold_wdata", h_wd[k], 64'hDEADBEEF00000000);
    end
    chk("sw_hold_beats", 64'(r_nb), 64'd1);
    run(1'b0, 3'd2, 14'h004, 64'h0, 0);
    chk("lw_rdata", r_data, 64'hFFFFFFFFDEADBEEF);
    run(1'b0, 3'd6, 14'h004, 64'h0, 0);
    chk("lwu_rdata", r_data, 64'h00000000DEADBEEF);
    run(1'b0, 3'd7, 14'h000, 64'h0, 0);
    chk("f7_fault", 64'(r_fault), 64'd1);
    chk("f7_lat", 64'(r_lat), 64'd1);
    chk("f7_beats", 64'(r_nb), 64'd0);
    run(1'b1, 3'd4, 14'h000, 64'h5, 0);
    chk("st4_fault", 64'(r_fault), 64'd1);
    chk("st4_beats", 64'(r_nb), 64'd0);
`ifdef LSU_MISALIGNED_EN
    run(1'b1, 3'd2, 14'h006, 64'hAABBCCDD, 0);
    chk("ssw_lat", 64'(r_lat), 64'd3);
    chk("ssw_beats", 64'(r_nb), 64'd2);
    chk("ssw_a0", 64'(lg_addr[nb0[5:0]]), 64'd0);
    chk("ssw_be0", 64'(lg_be[nb0[5:0]]), 64'hC0);
    chk("ssw_wd0", lg_wd[nb0[5:0]], 64'hCCDD000000000000);
    chk("ssw_a1", 64'(lg_addr[6'(nb0 + 1)]), 64'd1);
    chk("ssw_be1", 64'(lg_be[6'(nb0 + 1)]), 64'h03);
    chk("ssw_wd1", lg_wd[6'(nb0 + 1)], 64'h000000000000AABB);
    run(1'b0, 3'd2, 14'h006, 64'h0, 0);
    chk("slw_lat", 64'(r_lat), 64'd5);
    chk("slw_rdata", r_data, 64'hFFFFFFFFAABBCCDD);
    run(1'b1, 3'd1, 14'h3FFF, 64'h81A5, 0);
    chk("tsh_a0", 64'(lg_addr[nb0[5:0]]), 64'h7FF);
    chk("tsh_be0", 64'(lg_be[nb0[5:0]]), 64'h80);
    chk("tsh_a1", 64'(lg_addr[6'(nb0 + 1)]), 64'd0);
    chk("tsh_be1", 64'(lg_be[6'(nb0 + 1)]), 64'h01);
    chk("tsh_wd1", lg_wd[6'(nb0 + 1)], 64'h81);
    run(1'b0, 3'd1, 14'h3FFF, 64'h0, 0);
    chk("tlh_rdata", r_data, 64'hFFFFFFFFFFFF81A5);
`else
    run(1'b0, 3'd2, 14'h006, 64'h0, 0);
    chk("mis_fault", 64'(r_fault), 64'd1);
    chk("mis_lat", 64'(r_lat), 64'd1);
    chk("mis_beats", 64'(r_nb), 64'd0);
    chk("mis_rdata", r_data, 64'h0);
    run(1'b1, 3'd3, 14'h00C, 64'h1, 0);
    chk("mis_sd_fault", 64'(r_fault), 64'd1);
`endif
    @(negedge clk);
    gnt_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd3; req_addr = 14'h010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_req_before", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_req", 64'(mem_req), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 64'(resp_valid), 64'd0);
    run(1'b0, 3'd3, 14'h010, 64'h0, 0);
    chk("post_abort_ld", r_data, 64'h1122334480667788);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu_rv64.md
# lsu_rv64

RV64 load/store unit: the initiator side of the byte-addressed data memory interface. Accepts one load or store at a time from the execute stage, converts it into doubleword-wide memory beats with byte enables, and returns sign/zero-extended load data. Sits between the pipeline's memory stage and a synchronous 64-bit data RAM with a grant handshake and fixed one-cycle read latency.

## Interface
- AddrWidth, 14, byte-address width; must be ≥ 4; memory holds 2**(AddrWidth-3) doublewords
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- req_valid  in  1  pipeline request present
- req_ready  out  1  LSU can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  load: LB 0, LH 1, LW 2, LD 3, LBU 4, LHU 5, LWU 6; store: SB 0, SH 1, SW 2, SD 3
- req_addr  in  AddrWidth  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  64  extended load data; 0 for stores and faults
- resp_fault  out  1  request rejected, no memory access made
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  AddrWidth-3  doubleword index
- mem_be  out  8  byte enables, bit i = byte lane i
- mem_wdata  out  64  lane-aligned write data
- mem_gnt  in  1  memory accepts beat this cycle when mem_req=1
- mem_rdata  in  64  read data, valid the cycle after a granted read beat

## Operation
- Size = 1 << funct3[1:0]; offset o = req_addr[2:0]; index = req_addr[AddrWidth-1:3].
- Fault conditions: load funct3 = 7; store funct3 ≥ 4; misalignment per Configuration.
- Beat 0: index, lanes o .. min(7, o+size-1), wdata shifted left 8·o.
- Beat 1 (split only, o+size > 8): index+1 modulo 2**(AddrWidth-3) (wraps to 0 at top), lanes 0 .. o+size-9, wdata shifted right 8·(8-o).
- Loads assemble bytes from both beats, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD unchanged.
- States: IDLE → (accept) BEAT0, or RESP if fault. BEAT0 holds mem_req until mem_gnt; on grant: load → DATA0, store → BEAT1 if split else RESP. DATA0 captures mem_rdata → BEAT1 if split else RESP. BEAT1 holds mem_req until grant: load → DATA1, store → RESP. DATA1 captures → RESP. RESP asserts resp_valid → IDLE.
- mem_addr/mem_be/mem_wdata/mem_we stable while mem_req=1 and mem_gnt=0; mem_be=0, mem_req=0 outside BEAT states.
- Request fields latched on acceptance; later req_* changes ignored.

## Timing
- Reset: outputs req_ready=1 (IDLE), all others 0, on the cycle after rst_n sampled low; state IDLE.
- Reset mid-operation: abort to IDLE, mem_req drops, no resp_valid; granted beats are not rolled back.
- Accept at cycle T (req_valid & req_ready). With immediate grants: aligned store resp_valid at T+2; aligned load T+3; split store T+3; split load T+5; fault T+1.
- Each cycle of withheld mem_gnt adds one cycle.
- req_ready=0 from T+1 until the cycle after RESP; back-to-back throughput one request per (latency+1) cycles.

## Configuration
- LSU_MISALIGNED_EN defined: any offset legal; doubleword-crossing accesses split into two beats as above.
- Undefined: req_addr not a multiple of size → resp_fault=1, resp_rdata=0, no mem_req; BEAT1/DATA1 unreachable and may be removed.

## Test plan
- Reset with mem_req mid-BEAT0 → next cycle mem_req=0, req_ready=1, resp_valid=0.
- SD 0x1122334455667788 @0x010, then LD @0x010, gnt tied 1 → mem_be=0xFF, mem_addr=2; load resp_rdata=0x1122334455667788 at T+3.
- LB @0x013 with byte 0x80 in lane 3 → mem_be=0x08, resp_rdata=0xFFFFFFFFFFFFFF80; LBU → 0x0000000000000080.
- mem_gnt held 0 for 3 cycles during SW @0x004 data 0xDEADBEEF → mem_addr/be(0xF0)/wdata(0xDEADBEEF00000000) stable, resp_valid at T+5.
- With macro: SW @0x006 data 0xAABBCCDD → beats index 0 be 0xC0 wdata 0xCCDD000000000000, index 1 be 0x03 wdata 0xAABB; LW @0x006 returns 0xFFFFFFFFAABBCCDD. LH @ top byte (AddrWidth=14, 0x3FFF) → beat1 index 0.
- Without macro: LW @0x006 → resp_fault=1 at T+1, no mem_req; load funct3=7 @0x000 → resp_fault=1.
